// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU and load results queue in per-producer FIFOs and share the GPR write port round-robin.
// Decode reads a pending-write scoreboard. Defining WB_PERF_EN adds the perf_writes/perf_stalls counters.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef GPRS_COUNT
`define GPRS_COUNT 32
`endif

module wb_arbiter #(
    parameter int  N     = `XLEN,
    parameter int  GPRS  = `GPRS_COUNT,
    parameter int  DEPTH = 2,
    localparam int A     = $clog2(GPRS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         alu_valid,
    input  logic [A-1:0] alu_rd,
    input  logic [N-1:0] alu_data,
    output logic         alu_ready,
    input  logic         ld_valid,
    input  logic [A-1:0] ld_rd,
    input  logic [N-1:0] ld_data,
    output logic         ld_ready,
    output logic         we3,
    output logic [A-1:0] addr3,
    output logic [N-1:0] wd3,
    input  logic [A-1:0] q_addr1,
    input  logic [A-1:0] q_addr2,
    output logic         q_busy1,
    output logic         q_busy2
`ifdef WB_PERF_EN
    ,
    output logic [31:0]  perf_writes,
    output logic [31:0]  perf_stalls
`endif
);
    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic          PORT_ALU = 1'b0;
    localparam logic          PORT_LD  = 1'b1;

    logic [A-1:0]  rd_mem_q   [2][DEPTH];
    logic [N-1:0]  data_mem_q [2][DEPTH];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] rptr_q [2];
    logic [CW-1:0] cnt_q  [2];
    logic          rr_q, rr_d;
    logic          we3_q;
    logic [A-1:0]  addr3_q;
    logic [N-1:0]  wd3_q;

    logic [1:0]    in_valid_s, ready_s, push_s, pop_s, nonempty_s, busy_s;
    logic [A-1:0]  in_rd_s   [2];
    logic [N-1:0]  in_data_s [2];
    logic [A-1:0]  q_addr_s  [2];
    logic          grant_s, gsel_s;
    logic [A-1:0]  g_rd_s;
    logic [N-1:0]  g_data_s;
    logic [PW-1:0] off_s;

    // Channel gather: index 0 is the ALU, index 1 the load unit.
    always_comb begin
        in_valid_s   = {ld_valid, alu_valid};
        in_rd_s[0]   = alu_rd;
        in_rd_s[1]   = ld_rd;
        in_data_s[0] = alu_data;
        in_data_s[1] = ld_data;
        q_addr_s[0]  = q_addr1;
        q_addr_s[1]  = q_addr2;
    end

    // Handshake and round-robin grant; ready depends on registered occupancy and flush only.
    always_comb begin
        ready_s    = 2'b00;
        push_s     = 2'b00;
        nonempty_s = 2'b00;
        for (int p = 0; p < 2; p++) begin
            nonempty_s[p] = (cnt_q[p] != '0);
            ready_s[p]    = (cnt_q[p] != FULL_CNT) && !flush;
            push_s[p]     = in_valid_s[p] && ready_s[p] && (in_rd_s[p] != '0);
        end
        grant_s = 1'b0;
        gsel_s  = rr_q;
        rr_d    = rr_q;
        if (flush) begin
            grant_s = 1'b0;
        end else if (&nonempty_s) begin
            grant_s = 1'b1;
            gsel_s  = rr_q;
            rr_d    = ~rr_q;
        end else if (nonempty_s[0]) begin
            grant_s = 1'b1;
            gsel_s  = PORT_ALU;
        end else if (nonempty_s[1]) begin
            grant_s = 1'b1;
            gsel_s  = PORT_LD;
        end else begin
            grant_s = 1'b0;
        end
        pop_s    = {grant_s && gsel_s, grant_s && !gsel_s};
        g_rd_s   = rd_mem_q[gsel_s][rptr_q[gsel_s]];
        g_data_s = data_mem_q[gsel_s][rptr_q[gsel_s]];
    end

    // FIFO storage is written only on push, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push_s[p]) begin
                rd_mem_q[p][wptr_q[p]]   <= in_rd_s[p];
                data_mem_q[p][wptr_q[p]] <= in_data_s[p];
            end
        end
    end

    // FIFO pointers/occupancy, round-robin pointer and the write-port register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= '0;
                rptr_q[p] <= '0;
                cnt_q[p]  <= '0;
            end
            rr_q    <= PORT_LD;
            we3_q   <= 1'b0;
            addr3_q <= '0;
            wd3_q   <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (flush) begin
                    wptr_q[p] <= '0;
                    rptr_q[p] <= '0;
                    cnt_q[p]  <= '0;
                end else begin
                    if (push_s[p]) wptr_q[p] <= wptr_q[p] + PW'(1);
                    if (pop_s[p])  rptr_q[p] <= rptr_q[p] + PW'(1);
                    case ({push_s[p], pop_s[p]})
                        2'b10:   cnt_q[p] <= cnt_q[p] + CW'(1);
                        2'b01:   cnt_q[p] <= cnt_q[p] - CW'(1);
                        default: cnt_q[p] <= cnt_q[p];
                    endcase
                end
            end
            rr_q  <= rr_d;
            we3_q <= grant_s;
            if (grant_s) begin
                addr3_q <= g_rd_s;
                wd3_q   <= g_data_s;
            end
        end
    end

    // Scoreboard: live FIFO slots (offset from read pointer below occupancy) plus the write on the port.
    always_comb begin
        busy_s = 2'b00;
        off_s  = '0;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    off_s     = PW'(i) - rptr_q[p];
                    busy_s[k] = busy_s[k] | ((CW'(off_s) < cnt_q[p]) && (rd_mem_q[p][i] == q_addr_s[k]));
                end
            end
            busy_s[k] = (busy_s[k] | (we3_q && (addr3_q == q_addr_s[k]))) && (q_addr_s[k] != '0);
        end
    end

    assign alu_ready = ready_s[0];
    assign ld_ready  = ready_s[1];
    assign we3       = we3_q;
    assign addr3     = addr3_q;
    assign wd3       = wd3_q;
    assign q_busy1   = busy_s[0];
    assign q_busy2   = busy_s[1];

`ifdef WB_PERF_EN
    logic [31:0] perf_writes_q, perf_stalls_q;
    logic        stall_s;

    assign stall_s = |(in_valid_s & ~ready_s);

    // Performance counters; only reset clears them, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_writes_q <= 32'd0;
            perf_stalls_q <= 32'd0;
        end else begin
            perf_writes_q <= perf_writes_q + {31'd0, we3_q};
            perf_stalls_q <= perf_stalls_q + {31'd0, stall_s};
        end
    end

    assign perf_writes = perf_writes_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand sequences, and a queue-based random model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0, ld_rd = 5'd0, q_addr1 = 5'd0, q_addr2 = 5'd0;
    logic [31:0] alu_data = 32'd0, ld_data = 32'd0;
    logic        alu_ready, ld_ready, we3, q_busy1, q_busy2;
    logic [4:0]  addr3;
    logic [31:0] wd3;
`ifdef WB_PERF_EN
    logic [31:0] perf_writes, perf_stalls;
`endif

    wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .we3(we3), .addr3(addr3), .wd3(wd3),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2)
`ifdef WB_PERF_EN
        , .perf_writes(perf_writes), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Reference model: per-producer queues, alternating turn when both wait.
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        m_alu[$], m_ld[$];
    bit          m_turn_ld, m_we, p_ar, p_lr;
    logic [4:0]  m_addr;
    logic [31:0] m_wd;
    int          m_writes, m_stalls;

    function automatic bit m_busy(input logic [4:0] qa);
        if (qa == 5'd0) return 1'b0;
        if (m_we && m_addr == qa) return 1'b1;
        foreach (m_alu[i]) if (m_alu[i].rd == qa) return 1'b1;
        foreach (m_ld[i])  if (m_ld[i].rd == qa) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_edge(input bit fl, input bit av, input ent_t ae, input bit lv, input ent_t le,
                          input bit ar, input bit lr);
        bit   take_ld, any;
        ent_t e;
        if (m_we) m_writes++;
        if ((av && !ar) || (lv && !lr)) m_stalls++;
        if (fl) begin
            m_alu.delete();
            m_ld.delete();
            m_we = 1'b0;
        end else begin
            any = (m_alu.size() > 0) || (m_ld.size() > 0);
            if (m_alu.size() > 0 && m_ld.size() > 0) begin
                take_ld   = m_turn_ld;
                m_turn_ld = !m_turn_ld;
            end else begin
                take_ld = (m_ld.size() > 0);
            end
            m_we = any;
            if (any) begin
                e      = take_ld ? m_ld.pop_front() : m_alu.pop_front();
                m_addr = e.rd;
                m_wd   = e.data;
            end
            if (av && ar && ae.rd != 5'd0) m_alu.push_back(ae);
            if (lv && lr && le.rd != 5'd0) m_ld.push_back(le);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
        alu_rd = 5'd0; ld_rd = 5'd0; alu_data = 32'd0; ld_data = 32'd0;
        q_addr1 = 5'd0; q_addr2 = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_alu.delete(); m_ld.delete();
        m_we = 1'b0; m_addr = 5'd0; m_wd = 32'd0; m_turn_ld = 1'b1;
        m_writes = 0; m_stalls = 0; p_ar = 1'b1; p_lr = 1'b1;
    endtask

    typedef struct {
        logic fl, av; logic [4:0] ard; logic [31:0] ad;
        logic lv; logic [4:0] lrd; logic [31:0] ldd;
        logic [4:0] q1, q2;
        logic e_ar, e_lr, e_b1, e_b2, e_we; logic [4:0] e_addr; logic [31:0] e_wd;
    } vec_t;
    vec_t tbl [16];

    function automatic vec_t mk(input logic fl, av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                                input logic [4:0] q1, q2, input logic e_ar, e_lr, e_b1, e_b2, e_we,
                                input logic [4:0] e_addr, input logic [31:0] e_wd);
        vec_t v;
        v = '{fl, av, ard, ad, lv, lrd, ldd, q1, q2, e_ar, e_lr, e_b1, e_b2, e_we, e_addr, e_wd};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ai, li, nw;
        bit          saw_a, saw_l, ra, rl;
        logic [4:0]  log_a [16];
        logic [31:0] log_d [16];
        logic [4:0]  ea;
        ent_t        ae, le;

        // Pre-edge columns (ready, busy) then post-edge columns (we3, addr3, wd3).
        tbl[0]  = mk(0,1,5,32'hDEADBEEF,0,0,0,      5,0,   1,1,0,0, 0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,0,                 5,5,   1,1,1,1, 1,5,32'hDEADBEEF);
        tbl[2]  = mk(0,0,0,0,0,0,0,                 5,0,   1,1,1,0, 0,5,32'hDEADBEEF);
        tbl[3]  = mk(0,0,0,0,0,0,0,                 5,0,   1,1,0,0, 0,5,32'hDEADBEEF);
        tbl[4]  = mk(0,1,0,32'h1234,0,0,0,          0,0,   1,1,0,0, 0,5,32'hDEADBEEF);
        tbl[5]  = mk(0,0,0,0,0,0,0,                 0,0,   1,1,0,0, 0,5,32'hDEADBEEF);
        tbl[6]  = mk(0,0,0,0,0,0,0,                 0,5,   1,1,0,0, 0,5,32'hDEADBEEF);
        tbl[7]  = mk(0,1,3,32'h33,1,4,32'h44,       3,4,   1,1,0,0, 0,5,32'hDEADBEEF);
        tbl[8]  = mk(0,1,6,32'h66,1,7,32'h77,       3,4,   1,1,1,1, 1,4,32'h44);
        tbl[9]  = mk(0,1,8,32'h88,1,9,32'h99,       6,4,   0,1,1,1, 1,3,32'h33);
        tbl[10] = mk(0,1,8,32'h88,1,10,32'hAA,      7,8,   1,0,1,0, 1,7,32'h77);
        tbl[11] = mk(0,1,11,32'hBB,1,10,32'hAA,     9,8,   0,1,1,1, 1,6,32'h66);
        tbl[12] = mk(0,1,11,32'hBB,1,12,32'hCC,     11,10, 1,0,0,1, 1,9,32'h99);
        tbl[13] = mk(1,1,13,32'hDD,1,12,32'hCC,     8,10,  0,0,1,1, 0,9,32'h99);
        tbl[14] = mk(0,0,0,0,0,0,0,                 8,10,  1,1,0,0, 0,9,32'h99);
        tbl[15] = mk(0,0,0,0,0,0,0,                 11,9,  1,1,0,0, 0,9,32'h99);

        // Reset values.
        do_reset();
        q_addr1 = 5'd5; q_addr2 = 5'd9;
        #1;
        chk("rst_we3", we3, 1'b0);
        chk("rst_addr3", addr3, 5'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_busy1", q_busy1, 1'b0);
        chk("rst_busy2", q_busy2, 1'b0);
        @(negedge clk);

        // Directed vector table.
        for (int r = 0; r < 16; r++) begin
            flush = tbl[r].fl;
            alu_valid = tbl[r].av; alu_rd = tbl[r].ard; alu_data = tbl[r].ad;
            ld_valid = tbl[r].lv; ld_rd = tbl[r].lrd; ld_data = tbl[r].ldd;
            q_addr1 = tbl[r].q1; q_addr2 = tbl[r].q2;
            #1;
            chk($sformatf("tbl%0d_alu_ready", r), alu_ready, tbl[r].e_ar);
            chk($sformatf("tbl%0d_ld_ready", r), ld_ready, tbl[r].e_lr);
            chk($sformatf("tbl%0d_busy1", r), q_busy1, tbl[r].e_b1);
            chk($sformatf("tbl%0d_busy2", r), q_busy2, tbl[r].e_b2);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_we3", r), we3, tbl[r].e_we);
            chk($sformatf("tbl%0d_addr3", r), addr3, tbl[r].e_addr);
            chk($sformatf("tbl%0d_wd3", r), wd3, tbl[r].e_wd);
            @(negedge clk);
        end

        // Continuous two-producer traffic: LD first, then strict alternation.
        do_reset();
        ai = 0; li = 0; nw = 0; saw_a = 1'b0; saw_l = 1'b0;
        for (int c = 0; c < 40; c++) begin
            alu_valid = (ai < 8); alu_rd = 5'(ai + 1); alu_data = 32'hA000_0000 | 32'(ai + 1);
            ld_valid  = (li < 8); ld_rd  = 5'(li + 9); ld_data  = 32'hB000_0000 | 32'(li + 9);
            #1;
            ra = alu_ready; rl = ld_ready;
            if (alu_valid && !ra) saw_a = 1'b1;
            if (ld_valid && !rl) saw_l = 1'b1;
            @(posedge clk);
            if (alu_valid && ra) ai++;
            if (ld_valid && rl) li++;
            #1;
            if (we3) begin
                if (nw < 16) begin
                    log_a[nw] = addr3;
                    log_d[nw] = wd3;
                end
                nw++;
            end
            @(negedge clk);
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk("burst_write_count", 32'(nw), 32'd16);
        chk("burst_alu_ready_drop", {31'd0, saw_a}, 32'd1);
        chk("burst_ld_ready_drop", {31'd0, saw_l}, 32'd1);
        for (int i = 0; i < 16 && i < nw; i++) begin
            ea = (i % 2 == 0) ? 5'(9 + i / 2) : 5'(1 + i / 2);
            chk($sformatf("burst_addr%0d", i), log_a[i], ea);
            chk($sformatf("burst_data%0d", i), log_d[i],
                ((i % 2 == 0) ? 32'hB000_0000 : 32'hA000_0000) | 32'(ea));
        end

        // Asynchronous reset while a write is on the port and another is queued.
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h88;
        q_addr1 = 5'd7; q_addr2 = 5'd8;
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("arst_pre_we3", we3, 1'b1);
        chk("arst_pre_busy1", q_busy1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_we3", we3, 1'b0);
        chk("arst_addr3", addr3, 5'd0);
        chk("arst_wd3", wd3, 32'd0);
        chk("arst_alu_ready", alu_ready, 1'b1);
        chk("arst_busy1", q_busy1, 1'b0);
        chk("arst_busy2", q_busy2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_dropped_we3", we3, 1'b0);

`ifdef WB_PERF_EN
        // Ten isolated writes then three flushed stall cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'(i);
            @(negedge clk);
            alu_valid = 1'b0;
            @(negedge clk);
        end
        flush = 1'b1; alu_valid = 1'b1; alu_rd = 5'd3;
        repeat (3) @(negedge clk);
        flush = 1'b0; alu_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("perf_writes_dir", perf_writes, 32'd10);
        chk("perf_stalls_dir", perf_stalls, 32'd3);
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (!(alu_valid && !p_ar)) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!(ld_valid && !p_lr)) begin
                ld_valid = ($urandom_range(0, 9) < 6);
                ld_rd    = 5'($urandom_range(0, 7));
                ld_data  = $urandom;
            end
            flush   = ($urandom_range(0, 19) == 0);
            q_addr1 = 5'($urandom_range(0, 7));
            q_addr2 = 5'($urandom_range(0, 7));
            #1;
            p_ar = (m_alu.size() < DEPTH) && !flush;
            p_lr = (m_ld.size() < DEPTH) && !flush;
            chk("rnd_alu_ready", alu_ready, p_ar);
            chk("rnd_ld_ready", ld_ready, p_lr);
            chk("rnd_busy1", q_busy1, m_busy(q_addr1));
            chk("rnd_busy2", q_busy2, m_busy(q_addr2));
            @(posedge clk);
            ae = '{alu_rd, alu_data};
            le = '{ld_rd, ld_data};
            m_edge(flush, alu_valid, ae, ld_valid, le, p_ar, p_lr);
            #1;
            chk("rnd_we3", we3, m_we);
            chk("rnd_addr3", addr3, m_addr);
            chk("rnd_wd3", wd3, m_wd);
            @(negedge clk);
        end
`ifdef WB_PERF_EN
        chk("perf_writes_rnd", perf_writes, 32'(m_writes));
        chk("perf_stalls_rnd", perf_stalls, 32'(m_stalls));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
